conv8_psum_accum: RTL
=====================

# conv8_psum_accum

Downstream stage of the 8-bit 1D-systolic convolution row. Collects the serial stream of per-window partial sums the PE row emits (LANES psums per input-channel pass), accumulates them across CH input channels with a bias, requantizes (arithmetic shift, optional ReLU, saturation) and emits LANES 8-bit output activations over a valid/ready handshake toward the feature-map writer.

## Interface
- WIDTH, 8: activation width; psum width is 2*WIDTH.
- LANES, 4: psums per channel pass (one per PE in the row).
- CH, 3: input channels accumulated per output tile, ≥1.
- SHIFT, 6: requantization right shift, 0..2*WIDTH.
- ACC_W, 2*WIDTH+4: signed accumulator width; must hold CH*max|psum|+|bias|.

- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- i_clear  in  1  start a new tile; samples i_bias; aborts any tile in progress.
- i_bias  in  2*WIDTH  signed bias, sampled when i_clear=1.
- i_psum_valid  in  1  i_psum carries a psum this cycle.
- i_psum  in  2*WIDTH  signed partial sum.
- i_ready  in  1  consumer accepts o_data.
- o_valid  out  1  o_data valid.
- o_data  out  WIDTH  requantized activation.
- o_last  out  1  marks lane LANES-1 of the tile.
- o_busy  out  1  high in ACC, REQ, OUT.
- o_err  out  1  sticky: psum arrived outside ACC; cleared by i_clear or reset.

## Operation
- States: IDLE, ACC, REQ, OUT. Reset → IDLE; counters, accumulators, bias reg, out buffer, all outputs 0.
- i_clear (any state, highest priority): bias_reg←i_bias, lane_cnt←0, ch_cnt←0, o_err←0, o_valid←0, state→ACC. A psum valid in the same cycle is ignored and does not set o_err.
- ACC: per i_psum_valid: if ch_cnt==0, acc[lane_cnt]←sext(bias_reg)+sext(i_psum); else acc[lane_cnt]←acc[lane_cnt]+sext(i_psum). lane_cnt wraps LANES-1→0 and increments ch_cnt. Accepting lane LANES-1 of channel CH-1 → REQ. No i_psum_valid → hold.
- REQ (exactly 1 cycle): for each lane, s = acc >>> SHIFT (arithmetic, floor, no rounding); clamp per Configuration into out_buf; out_idx←0; → OUT.
- OUT: o_valid=1, o_data=out_buf[out_idx], o_last=(out_idx==LANES-1). On o_valid&i_ready: out_idx++; on last lane → IDLE, o_valid←0. o_data/o_last stable while stalled.
- i_psum_valid in IDLE, REQ or OUT: psum dropped, o_err←1.
- Accumulator overflow of ACC_W is a configuration error, not detected.

## Timing
- All outputs registered.
- Psum accepted at edge T is reflected in acc after T.
- Last psum accepted at edge T: REQ during cycle T+1, o_valid high from edge T+2 (2-cycle latency).
- Full back-to-back consumer (i_ready=1): LANES output cycles; IDLE after the last.
- Minimum tile period: LANES*CH + 1 + LANES cycles plus 1 for i_clear.
- Asynchronous reset mid-tile: all state lost, o_valid=0 immediately, tile not resumed.

## Configuration
- PSUM_RELU_EN defined: s<0 → 0; s>2^WIDTH-1 → 2^WIDTH-1; o_data unsigned.
- PSUM_RELU_EN undefined: signed saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; o_data two's complement.

## Test plan
- Defaults, i_clear bias=0, 12 psums of 64, i_ready=1 -> acc=192, o_data=3 on four consecutive cycles, o_last on 4th, o_valid first at 2 cycles after last psum.
- bias=-128, all psums=-640 -> acc=-2048, s=-32 -> o_data 0 with PSUM_RELU_EN, 0xE0 without.
- bias=0, all psums=32767 -> s=1535 -> o_data 255 (ReLU) / 127 (signed); lanes with psum=100 in the same tile -> s=4.
- Toggle i_ready 1,0,0,1 during OUT -> o_data/o_last held while stalled, exactly four handshakes, then IDLE, o_busy=0.
- Psum during OUT -> o_err=1, output values unchanged; next i_clear -> o_err=0.
- Assert rstn=0 mid-ACC and mid-OUT; also i_clear mid-ACC after 5 psums -> outputs 0 immediately / restart; subsequent 12-psum tile produces correct values with no residue from aborted tile.

Source files
------------

// File: rtl/conv8_psum_accum_if.sv
// Handshake/bus bundle between the PE-row psum stream, the accumulator stage and the feature-map writer.
// master drives the psum stream and consumer ready; slave is the accumulator stage.
interface conv8_psum_accum_if #(
    parameter int WIDTH = 8
);
    logic                 i_clear;
    logic [2*WIDTH-1:0]   i_bias;
    logic                 i_psum_valid;
    logic [2*WIDTH-1:0]   i_psum;
    logic                 i_ready;
    logic                 o_valid;
    logic [WIDTH-1:0]     o_data;
    logic                 o_last;
    logic                 o_busy;
    logic                 o_err;

    modport master (
        output i_clear, i_bias, i_psum_valid, i_psum, i_ready,
        input  o_valid, o_data, o_last, o_busy, o_err
    );

    modport slave (
        input  i_clear, i_bias, i_psum_valid, i_psum, i_ready,
        output o_valid, o_data, o_last, o_busy, o_err
    );
endinterface

// File: rtl/conv8_psum_accum.sv
// Psum accumulator / requantizer for the 8-bit systolic conv row: bias + CH channel passes, shift, clamp, serial out.
// Define PSUM_RELU_EN for ReLU with unsigned saturation; otherwise signed saturation.
//
// state | meaning
// IDLE  | no tile open; psums are dropped and flagged
// ACC   | accumulating LANES psums per channel pass over CH passes
// REQ   | one cycle: shift and clamp all lanes into the output buffer
// OUT   | presenting out_buf[out_idx] to the consumer until the last lane
module conv8_psum_accum #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CH    = 3,
    parameter int SHIFT = 6,
    parameter int ACC_W = 2*WIDTH+4
) (
    input logic               clk,
    input logic               rstn,
    conv8_psum_accum_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2**(WIDTH-1) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2**(WIDTH-1)));
    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'(2**WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        REQ  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [LW-1:0]               lane_cnt;
    logic [LW-1:0]               out_idx;
    logic [CW-1:0]               ch_cnt;
    logic signed [2*WIDTH-1:0]   bias_reg;
    logic signed [ACC_W-1:0]     acc     [LANES];
    logic signed [ACC_W-1:0]     shifted [LANES];
    logic [WIDTH-1:0]            sat     [LANES];
    logic [WIDTH-1:0]            out_buf [LANES];

    logic lane_last, ch_last, out_last, psum_take, hs;

    assign lane_last = (lane_cnt == LW'(LANES-1));
    assign ch_last   = (ch_cnt == CW'(CH-1));
    assign out_last  = (out_idx == LW'(LANES-1));
    assign psum_take = bus.i_psum_valid && !bus.i_clear && (state == ACC);
    assign hs        = bus.o_valid && bus.i_ready && (state == OUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.i_clear) begin
            state_nx = ACC;
        end else begin
            unique case (state)
                IDLE: state_nx = IDLE;
                ACC:  if (psum_take && lane_last && ch_last) state_nx = REQ;
                REQ:  state_nx = OUT;
                OUT:  if (hs && out_last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Floor shift then clamp; the lane-0 result also feeds o_data directly when leaving REQ.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            shifted[l] = acc[l] >>> SHIFT;
            sat[l]     = shifted[l][WIDTH-1:0];
`ifdef PSUM_RELU_EN
            if (shifted[l] < 0)          sat[l] = '0;
            else if (shifted[l] > U_MAX) sat[l] = U_MAX[WIDTH-1:0];
`else
            if (shifted[l] > S_MAX)      sat[l] = S_MAX[WIDTH-1:0];
            else if (shifted[l] < S_MIN) sat[l] = S_MIN[WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt     <= '0;
            ch_cnt       <= '0;
            out_idx      <= '0;
            bias_reg     <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_data   <= '0;
            bus.o_last   <= 1'b0;
            bus.o_busy   <= 1'b0;
            bus.o_err    <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                acc[l]     <= '0;
                out_buf[l] <= '0;
            end
        end else begin
            bus.o_busy <= (state_nx != IDLE);
            if (bus.i_clear) begin
                bias_reg    <= $signed(bus.i_bias);
                lane_cnt    <= '0;
                ch_cnt      <= '0;
                bus.o_err   <= 1'b0;
                bus.o_valid <= 1'b0;
                bus.o_last  <= 1'b0;
            end else begin
                if (bus.i_psum_valid && (state != ACC)) bus.o_err <= 1'b1;
                unique case (state)
                    ACC: begin
                        if (psum_take) begin
                            acc[lane_cnt] <= ((ch_cnt == '0) ? ACC_W'(bias_reg) : acc[lane_cnt])
                                             + ACC_W'($signed(bus.i_psum));
                            if (lane_last) begin
                                lane_cnt <= '0;
                                ch_cnt   <= ch_last ? '0 : ch_cnt + CW'(1);
                            end else begin
                                lane_cnt <= lane_cnt + LW'(1);
                            end
                        end
                    end
                    REQ: begin
                        for (int l = 0; l < LANES; l++) out_buf[l] <= sat[l];
                        out_idx     <= '0;
                        bus.o_valid <= 1'b1;
                        bus.o_data  <= sat[0];
                        bus.o_last  <= (LANES == 1);
                    end
                    OUT: begin
                        if (hs) begin
                            if (out_last) begin
                                bus.o_valid <= 1'b0;
                                bus.o_last  <= 1'b0;
                            end else begin
                                out_idx    <= out_idx + LW'(1);
                                bus.o_data <= out_buf[out_idx + LW'(1)];
                                bus.o_last <= ((out_idx + LW'(1)) == LW'(LANES-1));
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
